// File: rtl/boot_loader_if.sv
// Byte-stream handshake and program-memory write port of the boot loader.
interface boot_loader_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, prog_we, prog_addr, prog_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, prog_we, prog_addr, prog_wdata
  );
endinterface

// File: rtl/boot_loader.sv
// Program-memory loader: receives a length/words/checksum byte frame and writes
// 16-bit instruction words at sequential addresses while holding the core off.
module boot_loader #(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 4096
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          start,
  boot_loader_if.master bus,
  output logic          bootstrapping,
  output logic          done,
  output logic          error
);
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, WORD_HI, WORD_LO, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  acc;
  logic [15:0] len;
  logic [7:0]  hi_byte;
  logic [15:0] len_rx;
  logic        xfer, len_zero, len_big, last_word;

  // Length is judged from the stored high byte plus the low byte on the bus.
  assign len_rx    = {len[15:8], bus.rx_data};
  assign len_zero  = (len_rx == 16'd0);
  assign len_big   = (17'(len_rx) > 17'(MAX_WORDS));
  assign last_word = ((17'(bus.prog_addr) + 17'd1) == 17'(len));
  assign xfer      = bus.rx_valid & bus.rx_ready;

  always_comb begin
    state_nx      = state;
    bus.rx_ready  = 1'b0;
    bus.prog_we   = 1'b0;
    bootstrapping = 1'b0;
    unique case (state)
      IDLE, DONE, ERROR: if (start) state_nx = LEN_HI;
      LEN_HI: begin
        bus.rx_ready  = 1'b1;
        bootstrapping = 1'b1;
        if (bus.rx_valid) state_nx = LEN_LO;
      end
      LEN_LO: begin
        bus.rx_ready  = 1'b1;
        bootstrapping = 1'b1;
        if (bus.rx_valid) begin
          if (len_zero)     state_nx = CHECK;
          else if (len_big) state_nx = ERROR;
          else              state_nx = WORD_HI;
        end
      end
      WORD_HI: begin
        bus.rx_ready  = 1'b1;
        bootstrapping = 1'b1;
        if (bus.rx_valid) state_nx = WORD_LO;
      end
      WORD_LO: begin
        bus.rx_ready  = 1'b1;
        bootstrapping = 1'b1;
        if (bus.rx_valid) state_nx = WRITE;
      end
      WRITE: begin
        bus.prog_we   = 1'b1;
        bootstrapping = 1'b1;
        state_nx      = last_word ? CHECK : WORD_HI;
      end
      CHECK: begin
        bus.rx_ready  = 1'b1;
        bootstrapping = 1'b1;
        if (bus.rx_valid) state_nx = (bus.rx_data == acc) ? DONE : ERROR;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      acc            <= 8'd0;
      bus.prog_addr  <= '0;
      bus.prog_wdata <= 16'd0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      if ((state == IDLE || state == DONE || state == ERROR) && start) begin
        acc           <= 8'd0;
        bus.prog_addr <= '0;
        done          <= 1'b0;
        error         <= 1'b0;
      end
      // The checksum byte itself is never folded into the running sum.
      if (xfer && state != CHECK) acc <= acc + bus.rx_data;
      if (xfer && state == WORD_LO) bus.prog_wdata <= {hi_byte, bus.rx_data};
      if (state == WRITE) bus.prog_addr <= bus.prog_addr + ADDR_W'(1);
      if (xfer && state == LEN_LO && !len_zero && len_big) error <= 1'b1;
      if (xfer && state == CHECK) begin
        if (bus.rx_data == acc) done  <= 1'b1;
        else                    error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && state == LEN_HI)  len[15:8] <= bus.rx_data;
    if (xfer && state == LEN_LO)  len[7:0]  <= bus.rx_data;
    if (xfer && state == WORD_HI) hi_byte   <= bus.rx_data;
  end
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: framed loads, checksum/length errors, gaps,
// mid-frame start, async reset and the full-size 4096-word load.
module tb_boot_loader;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic arst_n;
  logic start;
  logic bootstrapping, done, error;
  int   total = 0;
  int   bad   = 0;
  int   viol  = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [15:0]       wr_data[$];
  logic [7:0]        fr[$];
  int                gp[$];

  boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(4096)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .bus(bus),
    .bootstrapping(bootstrapping), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.prog_we) begin
      wr_addr.push_back(bus.prog_addr);
      wr_data.push_back(bus.prog_wdata);
    end
    if (bus.prog_we && bus.rx_ready) viol++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr = {};
    wr_data = {};
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a falling edge; holds the byte until the loader takes it.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'hEE;
      @(negedge clk);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'hEE;
  endtask

  task automatic send_frame(input bit use_gaps);
    for (int i = 0; i < fr.size(); i++) send(fr[i], use_gaps ? gp[i] : 0);
  endtask

  task automatic check_two(input string pfx);
    chk({pfx, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk({pfx, "_a0"}, 32'(wr_addr[0]), 32'd0);
      chk({pfx, "_d0"}, 32'(wr_data[0]), 32'h3005);
      chk({pfx, "_a1"}, 32'(wr_addr[1]), 32'd1);
      chk({pfx, "_d1"}, 32'(wr_data[1]), 32'h7100);
    end
  endtask

  initial begin
    logic [7:0]  sum;
    logic [15:0] w;
    arst_n = 1'b0;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'hEE;
    repeat (2) @(negedge clk);
    chk("rst_rdy", bus.rx_ready, 0);
    chk("rst_we", bus.prog_we, 0);
    chk("rst_addr", 32'(bus.prog_addr), 0);
    chk("rst_wdata", 32'(bus.prog_wdata), 0);
    chk("rst_boot", bootstrapping, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    arst_n = 1'b1;
    @(negedge clk);

    // Good 2-word load with cycle-level checks
    fr = '{8'h00, 8'h02, 8'h30, 8'h05, 8'h71, 8'h00, 8'hA8};
    clear_log();
    pulse_start();
    chk("t1_boot_start", bootstrapping, 1);
    chk("t1_rdy_start", bus.rx_ready, 1);
    for (int i = 0; i < 4; i++) send(fr[i], 0);
    chk("t1_we_after_lo", bus.prog_we, 1);
    chk("t1_rdy_in_write", bus.rx_ready, 0);
    chk("t1_addr_w0", 32'(bus.prog_addr), 0);
    chk("t1_data_w0", 32'(bus.prog_wdata), 32'h3005);
    for (int i = 4; i < 7; i++) send(fr[i], 0);
    chk("t1_done", done, 1);
    chk("t1_err", error, 0);
    chk("t1_boot_end", bootstrapping, 0);
    check_two("t1");

    // Bad checksum, started from DONE
    fr[6] = 8'hA9;
    clear_log();
    pulse_start();
    chk("t2_done_cleared", done, 0);
    send_frame(0);
    chk("t2_err", error, 1);
    chk("t2_done", done, 0);
    check_two("t2");

    // Zero length, started from ERROR
    fr = '{8'h00, 8'h00, 8'h00};
    clear_log();
    pulse_start();
    chk("t3_err_cleared", error, 0);
    send_frame(0);
    chk("t3_done", done, 1);
    chk("t3_nwr", 32'(wr_addr.size()), 0);

    // Length one past the maximum
    clear_log();
    pulse_start();
    send(8'h10, 0);
    send(8'h01, 0);
    chk("t4_err", error, 1);
    chk("t4_done", done, 0);
    chk("t4_boot", bootstrapping, 0);
    repeat (3) @(negedge clk);
    chk("t4_rdy_stays0", bus.rx_ready, 0);
    chk("t4_nwr", 32'(wr_addr.size()), 0);

    // rx_valid gaps
    fr = '{8'h00, 8'h02, 8'h30, 8'h05, 8'h71, 8'h00, 8'hA8};
    gp = '{1, 0, 2, 3, 1, 2, 1};
    clear_log();
    pulse_start();
    send_frame(1);
    chk("t5_done", done, 1);
    chk("t5_err", error, 0);
    check_two("t5");

    // start pulsed mid-frame is ignored
    clear_log();
    pulse_start();
    for (int i = 0; i < 3; i++) send(fr[i], 0);
    pulse_start();
    chk("t6_boot_mid", bootstrapping, 1);
    for (int i = 3; i < 7; i++) send(fr[i], 0);
    chk("t6_done", done, 1);
    check_two("t6");

    // Async reset after first word written
    clear_log();
    pulse_start();
    for (int i = 0; i < 4; i++) send(fr[i], 0);
    @(negedge clk);
    chk("t7_nwr_before", 32'(wr_addr.size()), 1);
    #2 arst_n = 1'b0;
    #1;
    chk("t7_rdy", bus.rx_ready, 0);
    chk("t7_we", bus.prog_we, 0);
    chk("t7_addr", 32'(bus.prog_addr), 0);
    chk("t7_wdata", 32'(bus.prog_wdata), 0);
    chk("t7_boot", bootstrapping, 0);
    chk("t7_done", done, 0);
    chk("t7_err", error, 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    clear_log();
    pulse_start();
    send_frame(0);
    chk("t7_done_after", done, 1);
    check_two("t7");

    // Full-size load of MAX_WORDS words
    fr = '{8'h10, 8'h00};
    sum = 8'h10;
    for (int k = 0; k < 4096; k++) begin
      w = 16'(k) ^ 16'hA5C3;
      fr.push_back(w[15:8]);
      fr.push_back(w[7:0]);
      sum = sum + w[15:8] + w[7:0];
    end
    fr.push_back(sum);
    clear_log();
    pulse_start();
    send_frame(0);
    chk("t8_done", done, 1);
    chk("t8_err", error, 0);
    chk("t8_nwr", 32'(wr_addr.size()), 4096);
    if (wr_addr.size() == 4096) begin
      chk("t8_a0", 32'(wr_addr[0]), 0);
      chk("t8_d0", 32'(wr_data[0]), 32'hA5C3);
      chk("t8_alast", 32'(wr_addr[4095]), 4095);
      chk("t8_dlast", 32'(wr_data[4095]), 32'(16'd4095 ^ 16'hA5C3));
    end

    chk("we_rdy_overlap", 32'(viol), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
